// File: rtl/uart_pkg.sv
// Shared types and constant helpers for the TB-04 UART input path.
package uart_pkg;

   // Receiver frame states.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   // Clock cycles per bit (integer division).
   function automatic int div_of(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   // Cycles from start-edge detection to the middle of the start bit.
   function automatic int half_div_of(input int clk_hz, input int baud);
      return (clk_hz / baud) / 2;
   endfunction

   // Bits needed to index v entries; never less than one.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/uart_ini_rx_if.sv
// CPU-side nibble/status bus of the UART input path.
interface uart_ini_rx_if;
   logic       rd_nib;
   logic       clr_err;
   logic [3:0] in_nib;
   logic       nib_valid;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;

   // CPU side: strobes out, nibble and status in.
   modport master (
      output rd_nib, clr_err,
      input  in_nib, nib_valid, rx_busy, frame_err, overrun
   );

   // Receiver side.
   modport slave (
      input  rd_nib, clr_err,
      output in_nib, nib_valid, rx_busy, frame_err, overrun
   );
endinterface

// File: rtl/uart_byte_fifo.sv
// Small synchronous byte FIFO; DEPTH must be a power of two >= 2.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int PTR_W = clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [PTR_W:0]   cnt_q;
   logic             do_push, do_pop;

   assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rptr_q];

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_ini_rx.sv
// UART 8N1 receiver feeding the TB-04 input register one nibble at a time.
// Bytes land in a small FIFO; the CPU reads high nibble then low nibble.
module uart_ini_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 12_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          uart_rx,
   uart_ini_rx_if.slave  bus
);

   localparam int DIV   = div_of(CLK_HZ, BAUD);
   localparam int HALF  = half_div_of(CLK_HZ, BAUD);
   localparam int CNT_W = clog2(DIV);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

   // ---------------------------------------------------------------
   // Line synchronizer
   // ---------------------------------------------------------------
   logic sync1_q, rxs;

   // Two-flop synchronizer; resets to idle-high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         sync1_q <= uart_rx;
         rxs     <= sync1_q;
      end
   end

   // ---------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------
   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] divcnt_q, divcnt_d;
   logic [2:0]       bitpos_q, bitpos_d;
   logic [7:0]       shift_q, shift_d;
   logic             push_req;
   logic             ferr_set;

   // FSM state and bit-timing registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         divcnt_q <= '0;
         bitpos_q <= '0;
         shift_q  <= '0;
      end else begin
         state_q  <= state_d;
         divcnt_q <= divcnt_d;
         bitpos_q <= bitpos_d;
         shift_q  <= shift_d;
      end
   end

   // Next-state logic: sample mid start bit, then once per bit period.
   always_comb begin
      state_d  = state_q;
      divcnt_d = divcnt_q;
      bitpos_d = bitpos_q;
      shift_d  = shift_q;
      push_req = 1'b0;
      ferr_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rxs) begin
               state_d  = START;
               divcnt_d = '0;
            end
         end
         START: begin
            if (divcnt_q == CNT_MID) begin
               divcnt_d = '0;
               bitpos_d = '0;
               // A line back high by mid start bit was a glitch.
               state_d  = rxs ? IDLE : DATA;
            end else begin
               divcnt_d = divcnt_q + 1'b1;
            end
         end
         DATA: begin
            if (divcnt_q == CNT_LAST) begin
               divcnt_d = '0;
               shift_d  = {rxs, shift_q[7:1]};
               bitpos_d = bitpos_q + 3'd1;
               if (bitpos_q == 3'd7) state_d = STOP;
            end else begin
               divcnt_d = divcnt_q + 1'b1;
            end
         end
         STOP: begin
            if (divcnt_q == CNT_LAST) begin
               divcnt_d = '0;
               if (rxs) begin
                  push_req = 1'b1;
                  state_d  = IDLE;
               end else begin
                  ferr_set = 1'b1;
                  state_d  = BREAK;
               end
            end else begin
               divcnt_d = divcnt_q + 1'b1;
            end
         end
         BREAK: begin
            // Hold off until the line returns high so a long break is one error.
            if (rxs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Byte FIFO and nibble read-out
   // ---------------------------------------------------------------
   logic       fifo_full, fifo_empty;
   logic [7:0] head;
   logic       half_q;
   logic       pop, push, ovr_set;

   // Low nibble being consumed retires the head byte.
   assign pop     = bus.rd_nib & ~fifo_empty & half_q;
   assign push    = push_req & (~fifo_full | pop);
   assign ovr_set = push_req & fifo_full & ~pop;

   uart_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (shift_q),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head)
   );

   // Nibble selector; strobes while empty are ignored.
   always_ff @(posedge clk) begin
      if (rst)                            half_q <= 1'b0;
      else if (bus.rd_nib && !fifo_empty) half_q <= ~half_q;
   end

   // ---------------------------------------------------------------
   // Sticky error flags
   // ---------------------------------------------------------------
   logic frame_err_q, overrun_q;

   // A new error in the same cycle as clr_err keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (ferr_set)         frame_err_q <= 1'b1;
         else if (bus.clr_err) frame_err_q <= 1'b0;
         if (ovr_set)          overrun_q   <= 1'b1;
         else if (bus.clr_err) overrun_q   <= 1'b0;
      end
   end

   assign bus.nib_valid = ~fifo_empty;
   assign bus.in_nib    = fifo_empty ? 4'h0 : (half_q ? head[3:0] : head[7:4]);
   assign bus.rx_busy   = (state_q != IDLE);
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_ini_rx.sv
// Randomized + directed bench for uart_ini_rx against a byte-queue model.
module tb_uart_ini_rx;

   localparam int CLK_HZ = 12_000_000;
   localparam int BAUD   = 115200;
   localparam int DEPTH  = 4;
   localparam int DIV    = CLK_HZ / BAUD;
   localparam int HALF   = DIV / 2;

   logic tb04_clk = 1'b0;
   logic rst      = 1'b1;
   logic uart_rx  = 1'b1;

   uart_ini_rx_if cpu ();

   uart_ini_rx #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk     (tb04_clk),
      .rst     (rst),
      .uart_rx (uart_rx),
      .bus     (cpu)
   );

   always #5 tb04_clk = ~tb04_clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: received bytes, nibble phase, sticky flags.
   logic [7:0] mq [$];
   bit         half_m, ferr_m, ovr_m;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge tb04_clk);
      #1;
   endtask

   function automatic void m_frame(input logic [7:0] b, input bit good);
      if (!good)                 ferr_m = 1'b1;
      else if (mq.size() < DEPTH) mq.push_back(b);
      else                       ovr_m = 1'b1;
   endfunction

   function automatic void m_read();
      if (mq.size() != 0) begin
         if (half_m) begin
            half_m = 1'b0;
            void'(mq.pop_front());
         end else begin
            half_m = 1'b1;
         end
      end
   endfunction

   function automatic void m_reset();
      mq.delete();
      half_m = 1'b0;
      ferr_m = 1'b0;
      ovr_m  = 1'b0;
   endfunction

   // Compare all outputs with the model, line assumed idle.
   task automatic chk_model(input string tag);
      logic [3:0] en;
      @(negedge tb04_clk);
      en = 4'h0;
      if (mq.size() != 0) en = half_m ? mq[0][3:0] : mq[0][7:4];
      chk({tag, ".valid"}, cpu.nib_valid, mq.size() != 0);
      chk({tag, ".nib"},   cpu.in_nib,    en);
      chk({tag, ".ferr"},  cpu.frame_err, ferr_m);
      chk({tag, ".ovr"},   cpu.overrun,   ovr_m);
      chk({tag, ".busy"},  cpu.rx_busy,   1'b0);
   endtask

   // One 8N1 frame; a bad frame holds the line low for extra bit-times, then idles high.
   task automatic send_frame(input logic [7:0] b, input bit good, input int extra);
      uart_rx = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         tick(DIV);
      end
      uart_rx = good;
      tick(DIV);
      if (!good) begin
         tick(extra * DIV);
         uart_rx = 1'b1;
         tick(DIV);
      end
      m_frame(b, good);
   endtask

   task automatic rd();
      cpu.rd_nib = 1'b1;
      tick(1);
      cpu.rd_nib = 1'b0;
      m_read();
   endtask

   task automatic clr();
      cpu.clr_err = 1'b1;
      tick(1);
      cpu.clr_err = 1'b0;
      ferr_m = 1'b0;
      ovr_m  = 1'b0;
   endtask

   task automatic drain(input string tag);
      while (mq.size() != 0) begin
         chk_model(tag);
         rd();
      end
      chk_model(tag);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      bit         good;
      int         nr;

      cpu.rd_nib  = 1'b0;
      cpu.clr_err = 1'b0;
      m_reset();

      // Reset state
      rst = 1'b1;
      tick(3);
      chk_model("reset");
      rst = 1'b0;
      tick(2);

      // Single frame 0xA5, read both nibbles
      send_frame(8'hA5, 1'b1, 0);
      chk_model("a5");
      chk("a5.hi", cpu.in_nib, 4'hA);
      rd();
      chk_model("a5");
      chk("a5.lo", cpu.in_nib, 4'h5);
      rd();
      chk_model("a5.empty");

      // Short low glitch is rejected
      uart_rx = 1'b0;
      tick(10);
      @(negedge tb04_clk);
      chk("glitch.busy", cpu.rx_busy, 1'b1);
      repeat (10) @(posedge tb04_clk);
      #1;
      uart_rx = 1'b1;
      tick(50);
      chk_model("glitch");

      // Framing error with held-low line, then a clean frame
      send_frame(8'h3C, 1'b0, 2);
      chk_model("ferr");
      send_frame(8'h7E, 1'b1, 0);
      drain("ferr.7e");
      clr();
      chk_model("ferr.clr");

      // Overrun: five frames into a four-deep FIFO
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0);
      chk_model("ovr");
      drain("ovr.rd");
      clr();
      chk_model("ovr.clr");

      // Full FIFO: final low-nibble read coincides with the 0x99 push
      for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 0);
      chk_model("full");
      rd();
      chk_model("full.half");
      fork
         send_frame(8'h99, 1'b1, 0);
         begin
            tick(2 + HALF + 9 * DIV);
            rd();
         end
      join
      chk_model("coinc");
      drain("coinc.rd");

      // Reset in the middle of a frame
      send_frame(8'h11, 1'b1, 0);
      send_frame(8'h22, 1'b0, 0);
      uart_rx = 1'b0;
      tick(DIV);
      uart_rx = 1'b1;
      tick(4 * DIV);
      @(negedge tb04_clk);
      chk("mid.busy", cpu.rx_busy, 1'b1);
      rst = 1'b1;
      tick(2);
      m_reset();
      chk_model("midrst");
      rst = 1'b0;
      tick(2);
      send_frame(8'h42, 1'b1, 0);
      chk("42.hi", cpu.in_nib, 4'h4);
      drain("midrst.42");

      // Random frames, reads and clears
      for (int it = 0; it < 14; it++) begin
         b    = 8'($urandom);
         good = ($urandom_range(0, 5) != 0);
         send_frame(b, good, int'($urandom_range(0, 2)));
         chk_model("rnd.f");
         nr = int'($urandom_range(0, 3));
         for (int k = 0; k < nr; k++) begin
            rd();
            chk_model("rnd.r");
         end
         if ($urandom_range(0, 3) == 0) begin
            clr();
            chk_model("rnd.c");
         end
      end
      drain("rnd.drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
